sensor_input_conditioner: RTL and testbench
===========================================

// Module: sensor_input_conditioner
// PURPOSE
// - Upstream front end of the anti-theft alarm controller. Conditions the five raw vehicle switches
//   (ignition, brake, hidden, driver door, passenger door) before the alarm FSM sees them.
// - Each channel gets a 2-FF synchronizer and a per-channel debounce counter.
// - Outputs clean levels plus one-cycle rise/fall pulses, which the alarm FSM uses as its inputs.
// PARAMETERS
// - DEBOUNCE_CYCLES  16       consecutive synchronized cycles a new level must hold before it is accepted (>=1)
// - RESET_LEVELS     5'b11000 reset value of the clean levels, bit order {passenger,driver,hidden,brake,ignition}
// PORTS
// - clock              input   1  single system clock, all logic on rising edge
// - systemReset        input   1  synchronous, active-high reset
// - ignitionRaw        input   1  raw ignition switch (asynchronous, may bounce)
// - brakeRaw           input   1  raw brake pedal switch
// - hiddenRaw          input   1  raw hidden disarm switch
// - driverRaw          input   1  raw driver door switch
// - passengerRaw       input   1  raw passenger door switch
// - cleanLevel         output  5  debounced levels {passenger,driver,hidden,brake,ignition}
// - risePulse          output  5  1-cycle pulse when cleanLevel bit goes 0->1
// - fallPulse          output  5  1-cycle pulse when cleanLevel bit goes 1->0
// - anyDoorEvent       output  1  OR of rise/fall on driver or passenger, same cycle as the pulse
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Reset:
//   - cleanLevel=RESET_LEVELS; sync stages loaded with RESET_LEVELS.
//   - Counters=0; risePulse=fallPulse=0; anyDoorEvent=0.
// - Synchronizer: syncA<=raw, syncB<=syncA, per channel. Only syncB feeds the debounce logic.
// - Debounce, per channel, evaluated every cycle:
//   - syncB==cleanLevel: counter<=0.
//   - syncB!=cleanLevel and counter<DEBOUNCE_CYCLES-1: counter<=counter+1.
//   - syncB!=cleanLevel and counter==DEBOUNCE_CYCLES-1: cleanLevel<=syncB, counter<=0, matching pulse<=1.
//   - Otherwise pulses<=0, so a pulse is high exactly one cycle.
// - Latency: raw change set up before edge t0 gives syncB valid after t0+1, and cleanLevel changes at
//   edge t0+1+DEBOUNCE_CYCLES. Total is DEBOUNCE_CYCLES+2 edges.
// - Bounce: any cycle with syncB back at cleanLevel clears the counter. A glitch shorter than
//   DEBOUNCE_CYCLES synchronized cycles produces no output change and no pulse.
// - Channels are fully independent. Simultaneous changes on several channels update together, with
//   several pulse bits high in the same cycle.
// - Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter saturates logically and never wraps,
//   because it clears on acceptance.
// - DEBOUNCE_CYCLES=1: a level is accepted one cycle after it reaches syncB.
// - Reset mid-debounce: the counter is discarded and no pulse is generated. After reset, a raw level
//   differing from RESET_LEVELS is accepted after a full DEBOUNCE_CYCLES+2 edges and produces a pulse.
// - risePulse and fallPulse for the same bit are never high together.
// - anyDoorEvent = |{risePulse[4:3],fallPulse[4:3]}, registered-equivalent timing (same cycle as pulses).
// STRUCTURE
// - Shared package alarm_pkg:
//   - channel index constants CH_IGNITION=0, CH_BRAKE=1, CH_HIDDEN=2, CH_DRIVER=3, CH_PASSENGER=4;
//   - NUM_CHANNELS=5.
// - Sub-module debounce_channel:
//   - params DEBOUNCE_CYCLES and RESET_LEVEL;
//   - ports clock, systemReset, rawIn, level, rise, fall;
//   - instantiated 5x via generate.
// - Top: wiring, bit packing, anyDoorEvent OR.
// TESTING (DEBOUNCE_CYCLES=4, clock period 8)
// 1. Reset held 2 cycles with all raw=0
//    -> cleanLevel=5'b11000, pulses=0.
//    After release, driver/passenger fall accepted 6 edges later with fallPulse=5'b11000 for 1 cycle
//    and anyDoorEvent=1.
// 2. ignitionRaw 0->1 held steady
//    -> cleanLevel[0] rises exactly 6 edges after the first sampling edge; risePulse[0]=1 for exactly
//    1 cycle; other bits unchanged.
// 3. brakeRaw high for 3 cycles then low
//    -> cleanLevel[1] stays 0, no pulse.
//    Repeat with the pattern 3 high / 1 low / 4 high -> accepted only after the final 4-cycle run.
// 4. All five raw inputs toggle on the same edge
//    -> all cleanLevel bits change on the same cycle; rise/fall pulse bits match each direction.
// 5. hiddenRaw 0->1, systemReset asserted 1 cycle after 2 counted cycles
//    -> no pulse, cleanLevel[2]=0 after reset; then accepted 6 edges after release with risePulse[2].
// 6. Random bounce (1-3 cycle glitches) against a scoreboard model
//    -> cleanLevel never changes on a glitch shorter than 4 synchronized cycles; rise and fall never
//    both high.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the anti-theft alarm front end: channel indices and
// the helper that sizes the per-channel debounce counter.
package alarm_pkg;

    localparam int NUM_CHANNELS = 5;

    localparam int CH_IGNITION  = 0;
    localparam int CH_BRAKE     = 1;
    localparam int CH_HIDDEN    = 2;
    localparam int CH_DRIVER    = 3;
    localparam int CH_PASSENGER = 4;

    typedef logic [NUM_CHANNELS-1:0] chan_vec_t;

    // Wide enough to hold DEBOUNCE_CYCLES itself, even though the count stops one short.
    function automatic int count_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-FF synchronizer followed by a hold-time debouncer that
// emits single-cycle rise/fall pulses when a new level is accepted.
module debounce_channel
    import alarm_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clock,
    input  logic systemReset,
    input  logic rawIn,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            CW   = count_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic          sync_a_q, sync_a_d;
    logic          sync_b_q, sync_b_d;
    logic          level_q,  level_d;
    logic [CW-1:0] count_q,  count_d;
    logic          rise_q,   rise_d;
    logic          fall_q,   fall_d;

    // Next-state: synchronizer shift, counter advance/clear, level acceptance.
    always_comb begin
        sync_a_d = rawIn;
        sync_b_d = sync_a_q;
        level_d  = level_q;
        count_d  = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync_b_q != level_q) begin
            if (count_q == LAST) begin
                level_d = sync_b_q;
                rise_d  = sync_b_q;
                fall_d  = ~sync_b_q;
            end else begin
                count_d = count_q + ONE;
            end
        end else begin
            count_d = '0;
        end
    end

    // State register; reset drops any partial count so no pulse can escape.
    always_ff @(posedge clock) begin
        if (systemReset) begin
            sync_a_q <= RESET_LEVEL;
            sync_b_q <= RESET_LEVEL;
            level_q  <= RESET_LEVEL;
            count_q  <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_a_q <= sync_a_d;
            sync_b_q <= sync_b_d;
            level_q  <= level_d;
            count_q  <= count_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/sensor_input_conditioner.sv
// Conditions the five raw vehicle switches into clean levels and edge pulses
// for the alarm FSM.
module sensor_input_conditioner
    import alarm_pkg::*;
#(
    parameter int        DEBOUNCE_CYCLES = 16,
    parameter chan_vec_t RESET_LEVELS    = 5'b11000
) (
    input  logic                    clock,
    input  logic                    systemReset,
    input  logic                    ignitionRaw,
    input  logic                    brakeRaw,
    input  logic                    hiddenRaw,
    input  logic                    driverRaw,
    input  logic                    passengerRaw,
    output logic [NUM_CHANNELS-1:0] cleanLevel,
    output logic [NUM_CHANNELS-1:0] risePulse,
    output logic [NUM_CHANNELS-1:0] fallPulse,
    output logic                    anyDoorEvent
);

    chan_vec_t raw_s;
    chan_vec_t level_s;
    chan_vec_t rise_s;
    chan_vec_t fall_s;

    assign raw_s[CH_IGNITION]  = ignitionRaw;
    assign raw_s[CH_BRAKE]     = brakeRaw;
    assign raw_s[CH_HIDDEN]    = hiddenRaw;
    assign raw_s[CH_DRIVER]    = driverRaw;
    assign raw_s[CH_PASSENGER] = passengerRaw;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVELS[g])
        ) u_ch (
            .clock       (clock),
            .systemReset (systemReset),
            .rawIn       (raw_s[g]),
            .level       (level_s[g]),
            .rise        (rise_s[g]),
            .fall        (fall_s[g])
        );
    end

    assign cleanLevel = level_s;
    assign risePulse  = rise_s;
    assign fallPulse  = fall_s;

    // Built from the pulse flops directly, so it lines up with the pulses.
    assign anyDoorEvent = rise_s[CH_DRIVER] | rise_s[CH_PASSENGER]
                        | fall_s[CH_DRIVER] | fall_s[CH_PASSENGER];

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Directed and scoreboard checks of the sensor input conditioner with a
// 4-cycle debounce window.
module tb_sensor_input_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       systemReset;
    logic [4:0] raw_v;
    logic [4:0] cleanLevel, risePulse, fallPulse;
    logic       anyDoorEvent;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [4:0] raw;
        logic [4:0] exp_level;
        logic [4:0] exp_rise;
        logic [4:0] exp_fall;
        logic       exp_door;
    } vec_t;

    vec_t vecs[16];

    logic [4:0] ma, mb, ml;
    int         run[5];

    sensor_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .RESET_LEVELS    (5'b11000)
    ) dut (
        .clock        (clk),
        .systemReset  (systemReset),
        .ignitionRaw  (raw_v[0]),
        .brakeRaw     (raw_v[1]),
        .hiddenRaw    (raw_v[2]),
        .driverRaw    (raw_v[3]),
        .passengerRaw (raw_v[4]),
        .cleanLevel   (cleanLevel),
        .risePulse    (risePulse),
        .fallPulse    (fallPulse),
        .anyDoorEvent (anyDoorEvent)
    );

    always #4 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic [4:0] l, input logic [4:0] r,
                           input logic [4:0] f, input logic d);
        chk({nm, ".level"}, cleanLevel, l);
        chk({nm, ".rise"}, risePulse, r);
        chk({nm, ".fall"}, fallPulse, f);
        chk({nm, ".door"}, {4'b0000, anyDoorEvent}, {4'b0000, d});
    endtask

    task automatic step_chk(input string nm, input logic [4:0] l, input logic [4:0] r,
                            input logic [4:0] f, input logic d);
        tick();
        chk_all(nm, l, r, f, d);
    endtask

    // Scoreboard: consecutive synchronized disagreement count per channel.
    task automatic sb_step();
        logic [4:0] er;
        logic [4:0] ef;
        er = 5'b00000;
        ef = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            if (mb[i] != ml[i]) begin
                if (run[i] == D - 1) begin
                    ml[i] = mb[i];
                    run[i] = 0;
                    if (mb[i]) er[i] = 1'b1;
                    else       ef[i] = 1'b1;
                end else begin
                    run[i] = run[i] + 1;
                end
            end else begin
                run[i] = 0;
            end
        end
        mb = ma;
        ma = raw_v;
        tick();
        chk_all("random", ml, er, ef, |{er[4:3], ef[4:3]});
        chk("random.excl", risePulse & fallPulse, 5'b00000);
    endtask

    initial begin
        systemReset = 1'b1;
        raw_v       = 5'b00000;

        // Reset, door fall after release, then ignition rise.
        vecs[0]  = '{1'b1, 5'b00000, 5'b11000, 5'b00000, 5'b00000, 1'b0};
        vecs[1]  = '{1'b1, 5'b00000, 5'b11000, 5'b00000, 5'b00000, 1'b0};
        vecs[2]  = '{1'b0, 5'b00000, 5'b11000, 5'b00000, 5'b00000, 1'b0};
        vecs[3]  = '{1'b0, 5'b00000, 5'b11000, 5'b00000, 5'b00000, 1'b0};
        vecs[4]  = '{1'b0, 5'b00000, 5'b11000, 5'b00000, 5'b00000, 1'b0};
        vecs[5]  = '{1'b0, 5'b00000, 5'b11000, 5'b00000, 5'b00000, 1'b0};
        vecs[6]  = '{1'b0, 5'b00000, 5'b11000, 5'b00000, 5'b00000, 1'b0};
        vecs[7]  = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b11000, 1'b1};
        vecs[8]  = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[9]  = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[10] = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[11] = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[12] = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[13] = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[14] = '{1'b0, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 1'b0};
        vecs[15] = '{1'b0, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 1'b0};

        for (int v = 0; v < 16; v++) begin
            systemReset = vecs[v].rst;
            raw_v       = vecs[v].raw;
            step_chk($sformatf("vec%0d", v), vecs[v].exp_level, vecs[v].exp_rise,
                     vecs[v].exp_fall, vecs[v].exp_door);
        end

        // Brake glitch of 3 cycles is rejected.
        raw_v = 5'b00011;
        repeat (3) step_chk("brake3", 5'b00001, 5'b00000, 5'b00000, 1'b0);
        raw_v = 5'b00001;
        repeat (8) step_chk("brake3", 5'b00001, 5'b00000, 5'b00000, 1'b0);

        // 3 high / 1 low / 4 high: only the final run is accepted.
        raw_v = 5'b00011;
        repeat (3) step_chk("brake341", 5'b00001, 5'b00000, 5'b00000, 1'b0);
        raw_v = 5'b00001;
        step_chk("brake341", 5'b00001, 5'b00000, 5'b00000, 1'b0);
        raw_v = 5'b00011;
        repeat (5) step_chk("brake341", 5'b00001, 5'b00000, 5'b00000, 1'b0);
        step_chk("brake_acc", 5'b00011, 5'b00010, 5'b00000, 1'b0);
        step_chk("brake_post", 5'b00011, 5'b00000, 5'b00000, 1'b0);

        // All five toggle together.
        raw_v = 5'b11100;
        repeat (5) step_chk("all_wait", 5'b00011, 5'b00000, 5'b00000, 1'b0);
        step_chk("all_acc", 5'b11100, 5'b11100, 5'b00011, 1'b1);
        step_chk("all_post", 5'b11100, 5'b00000, 5'b00000, 1'b0);

        // Hidden falls, then its rise is interrupted by reset mid-count.
        raw_v = 5'b11000;
        repeat (5) step_chk("hid_fall_wait", 5'b11100, 5'b00000, 5'b00000, 1'b0);
        step_chk("hid_fall", 5'b11000, 5'b00000, 5'b00100, 1'b0);
        step_chk("hid_fall_post", 5'b11000, 5'b00000, 5'b00000, 1'b0);
        raw_v = 5'b11100;
        repeat (4) step_chk("hid_count", 5'b11000, 5'b00000, 5'b00000, 1'b0);
        systemReset = 1'b1;
        step_chk("hid_reset", 5'b11000, 5'b00000, 5'b00000, 1'b0);
        systemReset = 1'b0;
        repeat (5) step_chk("hid_after_rst", 5'b11000, 5'b00000, 5'b00000, 1'b0);
        step_chk("hid_acc", 5'b11100, 5'b00100, 5'b00000, 1'b0);
        step_chk("hid_post", 5'b11100, 5'b00000, 5'b00000, 1'b0);

        // Random bounce against the scoreboard, starting from a settled state.
        ma = 5'b11100;
        mb = 5'b11100;
        ml = 5'b11100;
        for (int i = 0; i < 5; i++) run[i] = 0;
        for (int it = 0; it < 60; it++) begin
            logic [4:0] base;
            logic [4:0] mask;
            base = raw_v;
            mask = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 3) == 0) begin
                raw_v = base ^ mask;
                repeat (8) sb_step();
            end else begin
                raw_v = base ^ mask;
                repeat ($urandom_range(1, 3)) sb_step();
                raw_v = base;
                repeat ($urandom_range(1, 4)) sb_step();
            end
        end
        repeat (8) sb_step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
